fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  IF stage. Owns the PC, issues in-order reads to instruction memory and
//  buffers the returned words. Presents INSTR_F / PCadd4_F to the IF/ID
//  pipeline register, which treats an all-zero INSTR_F as a bubble.
//  Honours decode stall (FDWrite=0) and redirects PC on taken branch/jump.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  DEPTH     2              buffer entries = max in-flight + buffered words (2..8)
// PORTS
//  CLK         in   1   clock, rising edge
//  RSTN        in   1   reset, asynchronous, active-low
//  IMEM_REQ    out  1   read request valid
//  IMEM_ADDR   out  32  read address (word aligned)
//  IMEM_READY  in   1   request accepted this cycle when IMEM_REQ=1
//  IMEM_RVALID in   1   read data valid; responses return in order, >=1 cycle after accept
//  IMEM_RDATA  in   32  read data
//  FDWrite     in   1   1 = IF/ID captures this cycle (head may pop); 0 = stall
//  BR_TAKEN    in   1   redirect request from EX
//  BR_TARGET   in   32  redirect address (bits[1:0] ignored, forced 0)
//  INSTR_F     out  32  head instruction; 0 when buffer empty
//  PCadd4_F    out  32  head PC+4; 0 when buffer empty
// BEHAVIOUR
//  Reset: PC=RESET_PC, state=IDLE, buffer/addr-queue empty, outstanding=0,
//   discard=0, IMEM_REQ=0, INSTR_F=0, PCadd4_F=0. IMEM is reset by same RSTN.
//  FSM: IDLE -> RUN unconditionally (one cycle after reset release).
//   RUN: IMEM_REQ=1 iff outstanding+occupancy < DEPTH and BR_TAKEN=0.
//   DRAIN: IMEM_REQ=0; entered on BR_TAKEN with responses still owed;
//    -> RUN when discard reaches 0 (same-cycle check after decrement).
//  Issue = IMEM_REQ & IMEM_READY: IMEM_ADDR=PC; PC+=4; PC pushed to addr queue;
//   outstanding++. IMEM_ADDR held stable while IMEM_REQ=1 and not accepted.
//  Response (IMEM_RVALID): if discard>0: drop, discard--, outstanding--;
//   else pop addr queue, push {RDATA, addr+4} into buffer, outstanding--.
//  Output: INSTR_F/PCadd4_F driven combinationally from buffer head (registered
//   storage). Pop when FDWrite=1 and buffer non-empty. Latency: accept at t,
//   RVALID at t+1 -> INSTR_F valid at t+2.
//  Redirect (BR_TAKEN=1, any state): buffer and addr queue cleared; no issue
//   this cycle; PC=BR_TARGET; discard = outstanding after this cycle's response
//   is counted (a response arriving same cycle is dropped); state = DRAIN if
//   discard>0 else RUN. Redirect in DRAIN accumulates, never loses count.
//  Simultaneous pop + response: both occur; occupancy unchanged.
//  Buffer can never overflow (issue gated by occupancy); RVALID with
//   outstanding=0 is a protocol error (assertion), ignored.
//  Fetched word 0x0000_0000 is passed through; IF/ID ignores it (known NOP).
//  All counters DEPTH-bounded, width $clog2(DEPTH+1); PC wraps modulo 2^32.
// TESTING
//  1 Reset, RESET_PC=0x100, IMEM 1-cycle latency, FDWrite=1 -> addrs 0x100,
//    0x104,0x108 issued; INSTR_F sequence matches mem, PCadd4_F=0x104,0x108,...
//  2 FDWrite=0 for 5 cycles -> after DEPTH=2 words buffered IMEM_REQ=0; head
//    held stable; on release words delivered in order, none lost/duplicated.
//  3 BR_TAKEN, BR_TARGET=0x200, 2 in flight, 3-cycle latency -> both stale
//    responses dropped, DRAIN 2 cycles, next IMEM_ADDR=0x200, INSTR_F=mem[0x200].
//  4 BR_TAKEN same cycle as IMEM_RVALID -> that word dropped, PCadd4_F next
//    valid = BR_TARGET+4; second BR_TAKEN in DRAIN -> final target wins.
//  5 IMEM_READY=0 for 3 cycles with REQ=1 -> IMEM_ADDR constant, PC not advanced.
//  6 RSTN pulsed low mid-DRAIN -> all outputs 0 immediately; after release
//    fetch restarts at RESET_PC, discard=0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC owner, in-order instruction fetch and return buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        FDWrite,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  output logic [31:0] INSTR_F,
  output logic [31:0] PCadd4_F
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [IW-1:0] idx_t;

  localparam logic [CW:0] DEPTH_W  = (CW + 1)'(DEPTH);
  localparam idx_t        LAST_IDX = idx_t'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        discard_q, discard_d;
  cnt_t        occ_q, occ_d;
  idx_t        buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  idx_t        aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  logic [31:0] buf_instr_q [DEPTH];
  logic [31:0] buf_instr_d [DEPTH];
  logic [31:0] buf_pc4_q   [DEPTH];
  logic [31:0] buf_pc4_d   [DEPTH];
  logic [31:0] aq_addr_q   [DEPTH];
  logic [31:0] aq_addr_d   [DEPTH];

  logic        issue, rsp, rsp_keep, pop;
  logic [CW:0] inflight_total;
  logic        unused_tgt;

  function automatic idx_t inc_idx(input idx_t i);
    return (i == LAST_IDX) ? '0 : i + idx_t'(1);
  endfunction

  // Word alignment is forced, so the low target bits carry no information.
  assign unused_tgt = ^BR_TARGET[1:0];

  // Requests only when every owed response plus every buffered word still fits.
  assign inflight_total = {1'b0, outstanding_q} + {1'b0, occ_q};
  assign IMEM_REQ  = (state_q == RUN) && (inflight_total < DEPTH_W) && !BR_TAKEN;
  assign IMEM_ADDR = pc_q;
  assign issue     = IMEM_REQ && IMEM_READY;
  assign rsp       = IMEM_RVALID && (outstanding_q != '0);
  assign rsp_keep  = rsp && (discard_q == '0) && !BR_TAKEN;
  assign pop       = FDWrite && (occ_q != '0);

  assign INSTR_F  = (occ_q != '0) ? buf_instr_q[buf_rd_q] : '0;
  assign PCadd4_F = (occ_q != '0) ? buf_pc4_q[buf_rd_q]   : '0;

  // Next-state: issue, response capture/drop, pop, and redirect flush.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    buf_rd_d      = buf_rd_q;
    buf_wr_d      = buf_wr_q;
    aq_rd_d       = aq_rd_q;
    aq_wr_d       = aq_wr_q;
    buf_instr_d   = buf_instr_q;
    buf_pc4_d     = buf_pc4_q;
    aq_addr_d     = aq_addr_q;
    outstanding_d = outstanding_q + cnt_t'(issue) - cnt_t'(rsp);
    occ_d         = occ_q + cnt_t'(rsp_keep) - cnt_t'(pop);

    if (issue) begin
      pc_d               = pc_q + 32'd4;
      aq_addr_d[aq_wr_q] = pc_q;
      aq_wr_d            = inc_idx(aq_wr_q);
    end
    if (rsp_keep) begin
      buf_instr_d[buf_wr_q] = IMEM_RDATA;
      buf_pc4_d[buf_wr_q]   = aq_addr_q[aq_rd_q] + 32'd4;
      buf_wr_d              = inc_idx(buf_wr_q);
      aq_rd_d               = inc_idx(aq_rd_q);
    end
    if (pop) begin
      buf_rd_d = inc_idx(buf_rd_q);
    end
    if (rsp && (discard_q != '0)) begin
      discard_d = discard_q - cnt_t'(1);
    end

    case (state_q)
      IDLE:    state_d = RUN;
      DRAIN:   if (discard_d == '0) state_d = RUN;
      default: state_d = state_q;
    endcase

    // A response landing in the redirect cycle belongs to the old stream.
    if (BR_TAKEN) begin
      pc_d      = {BR_TARGET[31:2], 2'b00};
      discard_d = outstanding_q - cnt_t'(rsp);
      state_d   = (discard_d != '0) ? DRAIN : RUN;
      occ_d     = '0;
      buf_rd_d  = '0;
      buf_wr_d  = '0;
      aq_rd_d   = '0;
      aq_wr_d   = '0;
    end
  end

  // All state registers, including the FSM, with asynchronous reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      occ_q         <= '0;
      buf_rd_q      <= '0;
      buf_wr_q      <= '0;
      aq_rd_q       <= '0;
      aq_wr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc4_q[i]   <= '0;
        aq_addr_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      occ_q         <= occ_d;
      buf_rd_q      <= buf_rd_d;
      buf_wr_q      <= buf_wr_d;
      aq_rd_q       <= aq_rd_d;
      aq_wr_q       <= aq_wr_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc4_q     <= buf_pc4_d;
      aq_addr_q     <= aq_addr_d;
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  rsp_without_req: assert property (@(posedge CLK) disable iff (!RSTN)
    !(IMEM_RVALID && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        FDWrite;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic [31:0] INSTR_F;
  logic [31:0] PCadd4_F;

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_READY(IMEM_READY),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .FDWrite(FDWrite), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
    .INSTR_F(INSTR_F), .PCadd4_F(PCadd4_F)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0, checks = 0, errors = 0, delivered = 0;
  int          cur_lat = 1, last_due = 0, mon_due = 0, first_acc = 0, stale = 0;
  logic        first_acc_v = 1'b0, lat_arm = 1'b0, hold_v = 1'b0;
  logic [31:0] stream_pc = RESET_PC, exp_issue = RESET_PC, hold_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_040C) return 32'h0;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: IMEM-side rules, memory acceptance, and delivered-stream scoreboard.
  always @(negedge CLK) begin
    if (!RSTN) begin
      check_bit("reset_req", IMEM_REQ, 1'b0);
      check("reset_instr", INSTR_F, 32'h0);
      check("reset_pc4", PCadd4_F, 32'h0);
      exp_issue   = RESET_PC;
      hold_v      = 1'b0;
      last_due    = 0;
      first_acc_v = 1'b0;
      stale       = 0;
    end else begin
      if (PCadd4_F == 32'h0) check("empty_instr", INSTR_F, 32'h0);
      if (hold_v && IMEM_REQ) check("addr_hold", IMEM_ADDR, hold_addr);
      hold_v    = IMEM_REQ && !IMEM_READY;
      hold_addr = IMEM_ADDR;
      check_bit("outstanding_bound", (pend.size() + int'(IMEM_RVALID)) <= DEPTH, 1'b1);
      if (IMEM_REQ) check("req_while_draining", 32'(stale), 32'h0);
      if (IMEM_RVALID && stale > 0) stale--;
      if (BR_TAKEN) begin
        check_bit("req_on_redirect", IMEM_REQ, 1'b0);
        exp_issue = {BR_TARGET[31:2], 2'b00};
        stale     = pend.size();
        hold_v    = 1'b0;
      end else if (IMEM_REQ && IMEM_READY) begin
        check("issue_addr", IMEM_ADDR, exp_issue);
        exp_issue = exp_issue + 32'd4;
        mon_due   = (cyc + cur_lat > last_due) ? cyc + cur_lat : last_due + 1;
        last_due  = mon_due;
        pend.push_back('{IMEM_ADDR, mon_due});
        if (!first_acc_v) begin
          first_acc_v = 1'b1;
          first_acc   = cyc;
        end
      end
      if (!BR_TAKEN && FDWrite && PCadd4_F != 32'h0) begin
        if (lat_arm) begin
          check("first_latency", 32'(cyc - first_acc), 32'd2);
          lat_arm = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got pc4 %h, expected no output", PCadd4_F);
        end else begin
          mon_e = exp_q.pop_front();
          check("instr", INSTR_F, mon_e.instr);
          check("pcadd4", PCadd4_F, mon_e.pc4);
          delivered++;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic rsp_due();
    return (pend.size() > 0) && (pend[0].due <= cyc);
  endfunction

  // Drives inputs for this cycle; also plays the in-order memory and the stream model.
  task automatic drive(input logic fd, input logic rdy, input logic br, input logic [31:0] tgt);
    FDWrite    = fd;
    IMEM_READY = rdy;
    BR_TAKEN   = br;
    BR_TARGET  = tgt;
    if (rsp_due()) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      IMEM_RVALID = 1'b0;
      IMEM_RDATA  = $urandom;
    end
    if (br) begin
      exp_q.delete();
      stream_pc = {tgt[31:2], 2'b00};
    end
    while (exp_q.size() < 6) begin
      exp_q.push_back('{mem_word(stream_pc), stream_pc + 32'd4});
      stream_pc = stream_pc + 32'd4;
    end
  endtask

  task automatic enter_reset();
    RSTN        = 1'b0;
    IMEM_RVALID = 1'b0;
    BR_TAKEN    = 1'b0;
    FDWrite     = 1'b0;
    IMEM_READY  = 1'b0;
    pend.delete();
    exp_q.delete();
    stream_pc   = RESET_PC;
  endtask

  logic        found;
  logic [31:0] snap, tgt;

  initial begin
    RSTN = 1'b1; FDWrite = 1'b0; IMEM_READY = 1'b0; IMEM_RVALID = 1'b0;
    IMEM_RDATA = '0; BR_TAKEN = 1'b0; BR_TARGET = '0;
    #2 enter_reset();
    repeat (3) next_cycle();

    // Sequential fetch from RESET_PC, one-cycle memory.
    RSTN = 1'b1; cur_lat = 1; lat_arm = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (20) begin next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); end

    // Decode stall: buffer fills, requests stop, head stays put.
    for (int i = 0; i < 8; i++) begin
      next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge CLK);
      if (i == 4) snap = INSTR_F;
      if (i >= 5) begin
        check_bit("stall_req", IMEM_REQ, 1'b0);
        check("stall_head", INSTR_F, snap);
        check_bit("stall_valid", PCadd4_F != 32'h0, 1'b1);
      end
    end
    repeat (10) begin next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); end

    // Redirect with two responses owed on a three-cycle memory.
    cur_lat = 3; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (pend.size() >= 2) begin found = 1'b1; break; end
      drive(1'b1, 1'b1, 1'b0, 32'h0);
    end
    check_bit("two_in_flight", found, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h200);
    repeat (25) begin next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); end

    // Redirect coinciding with a response, then a second redirect while draining.
    cur_lat = 2; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (rsp_due()) begin found = 1'b1; break; end
      drive(1'b1, 1'b1, 1'b0, 32'h0);
    end
    check_bit("rsp_at_redirect", found, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h300);
    next_cycle(); drive(1'b1, 1'b1, 1'b1, 32'h407);
    repeat (25) begin next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); end

    // Memory not ready: address held until accepted.
    cur_lat = 1;
    for (int i = 0; i < 5; i++) begin
      next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      if (i == 2) snap = IMEM_ADDR;
      if (i >= 2) check_bit("ready_low_req", IMEM_REQ, 1'b1);
      if (i >= 3) check("ready_low_addr", IMEM_ADDR, snap);
    end
    repeat (10) begin next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); end

    // Reset while draining stale responses.
    cur_lat = 4; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (pend.size() >= 1) begin found = 1'b1; break; end
      drive(1'b1, 1'b1, 1'b0, 32'h0);
    end
    check_bit("owed_before_reset", found, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h600);
    next_cycle();
    enter_reset();
    #1;
    check_bit("async_reset_req", IMEM_REQ, 1'b0);
    check("async_reset_instr", INSTR_F, 32'h0);
    check("async_reset_pc4", PCadd4_F, 32'h0);
    repeat (2) next_cycle();
    RSTN = 1'b1; cur_lat = 1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (30) begin next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      cur_lat = $urandom_range(1, 4);
      tgt = 32'h1000 + (32'($urandom_range(0, 4095)) << 2) + 32'($urandom_range(0, 3));
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
            $urandom_range(0, 99) < 4, tgt);
    end
    repeat (20) begin next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0); end

    @(negedge CLK);
    check_bit("progress", delivered > 200, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
